a78_stream_loader: RTL and testbench

- Streaming .a78 loader: consumes the file as a valid/ready byte stream and parses the 128-byte header on the fly, with no 128-byte buffer.
- Validates the magic text and ROM size, then packs ROM bytes into WORD_BYTES-wide little-endian words and writes them to PSRAM through a req/ack handshake.
- Successor to the fixed-width header parser/game loader pair. Sits between the SD block reader and the PSRAM controller.

---
 rtl/a78_stream_loader.sv | 205 ++++++++++++++++++++
 tb/tb_a78_stream_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a78_stream_loader.sv
// Streaming .a78 loader: parses the 128-byte header as it flows past, validates it,
// then packs ROM bytes into little-endian words and writes them to PSRAM via req/ack.
module a78_stream_loader #(
    parameter int                WORD_BYTES    = 2,
    parameter int                ADDR_W        = 22,
    parameter logic [ADDR_W-1:0] LOAD_BASE     = 22'h002000,
    parameter logic [31:0]       MAX_ROM_BYTES = 32'h00100000,
    parameter bit                CHECK_MAGIC   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wr_req,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic [WORD_BYTES-1:0]   wr_be,
    input  logic                    wr_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [31:0]             rom_size,
    output logic [15:0]             cart_type,
    output logic                    has_pokey,
    output logic [15:0]             pokey_addr,
    output logic                    tv_type,
    output logic [31:0]             bytes_written
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] WB32 = 32'(WORD_BYTES);

    state_t                    r_state, w_next;
    logic [6:0]                r_hdr_cnt;
    logic [31:0]               r_byte_cnt, r_hdr_size, r_rom_size, r_bytes_written;
    logic [15:0]               r_hdr_cart, r_cart_type, r_pokey_addr;
    logic                      r_hdr_tv, r_tv_type, r_has_pokey, r_magic_ok;
    logic                      r_done, r_error;
    logic [1:0]                r_err_code;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [8*WORD_BYTES-1:0]   r_wr_data;
    logic [WORD_BYTES-1:0]     r_wr_be;

    logic        w_abort, w_take, w_word_end, w_magic_bad, w_size_bad;
    logic        w_done_nxt, w_err_nxt;
    logic [31:0] w_lane, w_lanes_set;
    logic [ADDR_W-1:0] w_word_addr;

    function automatic logic [7:0] magic_char(input logic [6:0] idx);
        case (idx)
            7'd1, 7'd3: return 8'h41;
            7'd2:       return 8'h54;
            7'd4:       return 8'h52;
            7'd5:       return 8'h49;
            7'd6:       return 8'h37;
            7'd7:       return 8'h38;
            7'd8, 7'd9: return 8'h30;
            default:    return 8'h00;
        endcase
    endfunction

    // Returns {has_pokey, pokey_addr}; higher cart_type bits win.
    function automatic logic [16:0] pokey_decode(input logic [15:0] cart);
        if (cart[15])      return {1'b1, 16'h0800};
        else if (cart[10]) return {1'b1, 16'h0440};
        else if (cart[6])  return {1'b1, 16'h0450};
        else if (cart[0])  return {1'b1, 16'h4000};
        else               return 17'h0;
    endfunction

    assign w_abort     = abort && (r_state != S_IDLE) && (r_state != S_ERR);
    assign w_take      = in_valid && in_ready;
    assign w_lane      = r_byte_cnt % WB32;
    assign w_word_end  = (w_lane == WB32 - 32'd1) || (r_byte_cnt + 32'd1 == r_rom_size);
    assign w_magic_bad = CHECK_MAGIC && !r_magic_ok;
    assign w_size_bad  = (r_hdr_size == 32'd0) || (r_hdr_size > MAX_ROM_BYTES);
    assign w_word_addr = LOAD_BASE + ADDR_W'(r_byte_cnt / WB32);

    always_comb begin
        w_lanes_set = 32'd0;
        for (int i = 0; i < WORD_BYTES; i++)
            w_lanes_set = w_lanes_set + 32'(r_wr_be[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_ERR;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_HEADER;
                S_HEADER: if (w_take && r_hdr_cnt == 7'd127) w_next = S_CHECK;
                S_CHECK:  w_next = (w_magic_bad || w_size_bad) ? S_ERR : S_DATA;
                S_DATA:   if (w_take && w_word_end) w_next = S_WRITE;
                S_WRITE:  if (wr_ack) w_next = (r_byte_cnt == r_rom_size) ? S_DONE : S_DATA;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // abort gates in_ready so a byte is never handshaken and then dropped.
    always_comb begin
        in_ready   = ((r_state == S_HEADER) || (r_state == S_DATA)) && !abort;
        wr_req     = (r_state == S_WRITE);
        busy       = (r_state != S_IDLE);
        w_done_nxt = (r_state == S_DONE) && !w_abort;
        w_err_nxt  = (r_state == S_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr_cnt <= '0;  r_byte_cnt <= '0;  r_hdr_size <= '0;  r_rom_size <= '0;
            r_bytes_written <= '0;  r_hdr_cart <= '0;  r_cart_type <= '0;
            r_pokey_addr <= '0;  r_hdr_tv <= 1'b0;  r_tv_type <= 1'b0;
            r_has_pokey <= 1'b0;  r_magic_ok <= 1'b0;  r_done <= 1'b0;
            r_error <= 1'b0;  r_err_code <= '0;  r_wr_addr <= '0;
            r_wr_data <= '0;  r_wr_be <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_error <= w_err_nxt;
            if (w_abort) begin
                r_err_code <= 2'd3;
                r_wr_be    <= '0;
                r_wr_data  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_hdr_cnt       <= '0;
                        r_byte_cnt      <= '0;
                        r_bytes_written <= '0;
                        r_wr_be         <= '0;
                        r_wr_data       <= '0;
                        r_err_code      <= '0;
                        r_magic_ok      <= 1'b1;
                    end
                    S_HEADER: if (w_take) begin
                        r_hdr_cnt <= r_hdr_cnt + 7'd1;
                        if (r_hdr_cnt >= 7'd1 && r_hdr_cnt <= 7'd9 && in_data != magic_char(r_hdr_cnt))
                            r_magic_ok <= 1'b0;
                        case (r_hdr_cnt)
                            7'd49:   r_hdr_size[7:0]   <= in_data;
                            7'd50:   r_hdr_size[15:8]  <= in_data;
                            7'd51:   r_hdr_size[23:16] <= in_data;
                            7'd52:   r_hdr_size[31:24] <= in_data;
                            7'd53:   r_hdr_cart[7:0]   <= in_data;
                            7'd54:   r_hdr_cart[15:8]  <= in_data;
                            7'd57:   r_hdr_tv          <= in_data[0];
                            default: ;
                        endcase
                    end
                    S_CHECK: begin
                        r_rom_size  <= r_hdr_size;
                        r_cart_type <= r_hdr_cart;
                        r_tv_type   <= r_hdr_tv;
                        {r_has_pokey, r_pokey_addr} <= pokey_decode(r_hdr_cart);
                        if (w_magic_bad)     r_err_code <= 2'd1;
                        else if (w_size_bad) r_err_code <= 2'd2;
                    end
                    S_DATA: if (w_take) begin
                        for (int i = 0; i < WORD_BYTES; i++) begin
                            if (w_lane == 32'(i)) begin
                                r_wr_data[i*8 +: 8] <= in_data;
                                r_wr_be[i]          <= 1'b1;
                            end
                        end
                        r_byte_cnt <= r_byte_cnt + 32'd1;
                        if (w_word_end) r_wr_addr <= w_word_addr;
                    end
                    S_WRITE: if (wr_ack) begin
                        r_bytes_written <= r_bytes_written + w_lanes_set;
                        r_wr_be         <= '0;
                        r_wr_data       <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done          = r_done;
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign wr_be         = r_wr_be;
    assign rom_size      = r_rom_size;
    assign cart_type     = r_cart_type;
    assign has_pokey     = r_has_pokey;
    assign pokey_addr    = r_pokey_addr;
    assign tv_type       = r_tv_type;
    assign bytes_written = r_bytes_written;

endmodule

// File: tb/tb_a78_stream_loader.sv
// Bench for a78_stream_loader: a WORD_BYTES=2 instance with magic checking and a
// WORD_BYTES=4 instance without, checked against a header/ROM-level model.
module tb_a78_stream_loader;

    localparam logic [31:0] MAXB = 32'h00100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       sel = 1'b0;
    logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, wr_ack = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        a_in_ready, a_wr_req, a_busy, a_done, a_error, a_has_pokey, a_tv_type;
    logic [21:0] a_wr_addr;
    logic [15:0] a_wr_data, a_cart_type, a_pokey_addr;
    logic [1:0]  a_wr_be, a_err_code;
    logic [31:0] a_rom_size, a_bytes_written;

    logic        b_in_ready, b_wr_req, b_busy, b_done, b_error, b_has_pokey, b_tv_type;
    logic [21:0] b_wr_addr;
    logic [31:0] b_wr_data;
    logic [15:0] b_cart_type, b_pokey_addr;
    logic [3:0]  b_wr_be;
    logic [1:0]  b_err_code;
    logic [31:0] b_rom_size, b_bytes_written;

    a78_stream_loader #(.WORD_BYTES(2)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start & ~sel), .abort(abort & ~sel),
        .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .wr_ack(wr_ack & ~sel), .busy(a_busy), .done(a_done), .error(a_error),
        .err_code(a_err_code), .rom_size(a_rom_size), .cart_type(a_cart_type),
        .has_pokey(a_has_pokey), .pokey_addr(a_pokey_addr), .tv_type(a_tv_type),
        .bytes_written(a_bytes_written));

    a78_stream_loader #(.WORD_BYTES(4), .CHECK_MAGIC(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start & sel), .abort(abort & sel),
        .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
        .wr_ack(wr_ack & sel), .busy(b_busy), .done(b_done), .error(b_error),
        .err_code(b_err_code), .rom_size(b_rom_size), .cart_type(b_cart_type),
        .has_pokey(b_has_pokey), .pokey_addr(b_pokey_addr), .tv_type(b_tv_type),
        .bytes_written(b_bytes_written));

    logic        m_in_ready, m_wr_req, m_busy, m_done, m_error, m_has_pokey, m_tv_type;
    logic [21:0] m_wr_addr;
    logic [31:0] m_wr_data, m_rom_size, m_bytes_written;
    logic [15:0] m_cart_type, m_pokey_addr;
    logic [3:0]  m_wr_be;
    logic [1:0]  m_err_code;

    always_comb begin
        m_in_ready = sel ? b_in_ready : a_in_ready;
        m_wr_req   = sel ? b_wr_req   : a_wr_req;
        m_busy     = sel ? b_busy     : a_busy;
        m_done     = sel ? b_done     : a_done;
        m_error    = sel ? b_error    : a_error;
        m_wr_addr  = sel ? b_wr_addr  : a_wr_addr;
        m_wr_data  = sel ? b_wr_data  : {16'h0, a_wr_data};
        m_wr_be    = sel ? b_wr_be    : {2'b00, a_wr_be};
        m_err_code = sel ? b_err_code : a_err_code;
        m_rom_size = sel ? b_rom_size : a_rom_size;
        m_cart_type  = sel ? b_cart_type  : a_cart_type;
        m_has_pokey  = sel ? b_has_pokey  : a_has_pokey;
        m_pokey_addr = sel ? b_pokey_addr : a_pokey_addr;
        m_tv_type    = sel ? b_tv_type    : a_tv_type;
        m_bytes_written = sel ? b_bytes_written : a_bytes_written;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { logic [21:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
    wr_t         exp_q[$];
    wr_t         e_w;
    logic [7:0]  hdr[128];
    logic [7:0]  rom[$];
    int          exp_code = 0;
    logic [31:0] exp_size = 0, exp_bw = 0;
    logic [15:0] exp_cart = 0, exp_paddr = 0;
    logic        exp_tv = 0, exp_has = 0;

    task automatic set_rom(input logic [7:0] first, input int n);
        rom.delete();
        for (int i = 0; i < n; i++) rom.push_back(first + 8'(i));
    endtask

    task automatic model_expect(input bit s, input logic [31:0] size, input logic [15:0] cart,
                                input logic tv, input bit bad);
        string magic = "ATARI7800";
        int wb = s ? 4 : 2;
        logic [31:0] d;
        logic [3:0]  be;
        for (int i = 0; i < 128; i++) hdr[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 9; i++) hdr[1+i] = magic[i];
        if (bad) hdr[5] = "X";
        for (int i = 0; i < 4; i++) hdr[49+i] = size[8*i +: 8];
        hdr[53] = cart[7:0];
        hdr[54] = cart[15:8];
        hdr[57] = 8'hA4 | {7'h0, tv};
        exp_code = (!s && bad) ? 1 : ((size == 0 || size > MAXB) ? 2 : 0);
        exp_size = size; exp_cart = cart; exp_tv = tv;
        if (cart[15])      begin exp_has = 1; exp_paddr = 16'h0800; end
        else if (cart[10]) begin exp_has = 1; exp_paddr = 16'h0440; end
        else if (cart[6])  begin exp_has = 1; exp_paddr = 16'h0450; end
        else if (cart[0])  begin exp_has = 1; exp_paddr = 16'h4000; end
        else               begin exp_has = 0; exp_paddr = 16'h0000; end
        exp_bw = (exp_code == 0) ? size : 32'd0;
        exp_q.delete();
        if (exp_code == 0) begin
            for (int w = 0; w * wb < int'(size); w++) begin
                d = 0; be = 0;
                for (int k = 0; k < wb; k++) begin
                    if (w * wb + k < int'(size)) begin
                        d  = d | (32'(rom[w*wb+k]) << (8*k));
                        be = be | 4'(1 << k);
                    end
                end
                exp_q.push_back('{addr: 22'h002000 + 22'(w), data: d, be: be});
            end
        end
    endtask

    // ---------------- compare process ----------------
    int          cyc = 0, last_ack_cyc = 0, n_done = 0, n_err = 0;
    bit          comp_en = 1'b0, req_seen = 1'b0;
    logic        p_req = 1'b0, p_ack = 1'b0;
    logic [21:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_fields(input string tag);
        chk({tag, "_rom_size"}, m_rom_size, exp_size);
        chk({tag, "_cart_type"}, 32'(m_cart_type), 32'(exp_cart));
        chk({tag, "_has_pokey"}, 32'(m_has_pokey), 32'(exp_has));
        chk({tag, "_pokey_addr"}, 32'(m_pokey_addr), 32'(exp_paddr));
        chk({tag, "_tv_type"}, 32'(m_tv_type), 32'(exp_tv));
    endtask

    always @(negedge clk) begin
        if (comp_en) begin
            if (m_wr_req) begin
                req_seen = 1'b1;
                chk("in_ready_during_write", 32'(m_in_ready), 32'd0);
            end
            if (m_wr_req && p_req && !p_ack) begin
                chk("hold_addr", 32'(m_wr_addr), 32'(p_addr));
                chk("hold_data", m_wr_data, p_data);
                chk("hold_be", 32'(m_wr_be), 32'(p_be));
            end
            if (m_wr_req && wr_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_count", 32'(exp_q.size()), 32'd1);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("wr_addr", 32'(m_wr_addr), 32'(e_w.addr));
                    chk("wr_data", m_wr_data, e_w.data);
                    chk("wr_be", 32'(m_wr_be), 32'(e_w.be));
                end
                last_ack_cyc = cyc;
            end
            if (m_done) begin
                n_done++;
                chk("done_latency", 32'(cyc - last_ack_cyc), 32'd2);
                chk("done_code_expected", 32'(exp_code), 32'd0);
                chk("done_bytes_written", m_bytes_written, exp_bw);
                chk("done_writes_left", 32'(exp_q.size()), 32'd0);
                chk_fields("done");
            end
            if (m_error) begin
                n_err++;
                chk("err_code", 32'(m_err_code), 32'(exp_code));
                chk_fields("err");
                if (exp_code != 3) chk("err_no_wr_req", 32'(req_seen), 32'd0);
            end
        end
        p_req = m_wr_req; p_ack = wr_ack;
        p_addr = m_wr_addr; p_data = m_wr_data; p_be = m_wr_be;
    end

    // ---------------- PSRAM ack responder ----------------
    int ack_delay = 0, ack_cnt = 0;
    bit ack_en = 1'b1;

    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            wr_ack = 1'b0; ack_cnt = 0;
        end else if (wr_ack) begin
            wr_ack = 1'b0; ack_cnt = 0;
        end else if (m_wr_req && ack_en) begin
            if (ack_cnt >= ack_delay) wr_ack = 1'b1;
            else ack_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_in_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("in_ready_timeout", 32'(m_in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        req_seen = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n0 = n_done, e0 = n_err;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (n_done != n0 || n_err != e0) break;
        end
        #1;
        chk("outcome_done", 32'(n_done - n0), (exp_code == 0) ? 32'd1 : 32'd0);
        chk("outcome_error", 32'(n_err - e0), (exp_code != 0) ? 32'd1 : 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic stream_load(input bit send_rom);
        do_start();
        for (int i = 0; i < 128; i++) send_byte(hdr[i]);
        if (exp_code != 0) begin
            @(negedge clk);
            chk("in_ready_after_hdr", 32'(m_in_ready), 32'd0);
        end else if (send_rom) begin
            foreach (rom[i]) send_byte(rom[i]);
        end
        wait_end();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(m_in_ready), 0);
        chk({tag, "_wr_req"}, 32'(m_wr_req), 0);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done_error"}, 32'({m_done, m_error}), 0);
        chk({tag, "_err_code"}, 32'(m_err_code), 0);
        chk({tag, "_wr_addr"}, 32'(m_wr_addr), 0);
        chk({tag, "_wr_data"}, m_wr_data, 0);
        chk({tag, "_wr_be"}, 32'(m_wr_be), 0);
        chk({tag, "_rom_size"}, m_rom_size, 0);
        chk({tag, "_cart_pokey"}, {m_cart_type, m_pokey_addr}, 0);
        chk({tag, "_has_pokey_tv"}, 32'({m_has_pokey, m_tv_type}), 0);
        chk({tag, "_bytes_written"}, m_bytes_written, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values on both instances
        #23;
        sel = 1'b0; #1; chk_all_zero("reset_a");
        sel = 1'b1; #1; chk_all_zero("reset_b");
        sel = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        comp_en = 1'b1;

        // Size 6, WORD_BYTES=2
        set_rom(8'h11, 6);
        model_expect(1'b0, 32'd6, 16'h0000, 1'b1, 1'b0);
        chk("model_w0_data", exp_q[0].data, 32'h1211);
        chk("model_w2_addr", 32'(exp_q[2].addr), 32'h2002);
        chk("model_w2_data", exp_q[2].data, 32'h1615);
        stream_load(1'b1);
        chk("t1_bytes_written", m_bytes_written, 32'd6);

        // Size 5, WORD_BYTES=4, POKEY at 0x0800
        sel = 1'b1;
        set_rom(8'h01, 5);
        model_expect(1'b1, 32'd5, 16'h8441, 1'b0, 1'b0);
        chk("model_b_w0_data", exp_q[0].data, 32'h04030201);
        chk("model_b_w1_be", 32'(exp_q[1].be), 32'h1);
        stream_load(1'b1);
        chk("t2_bytes_written", m_bytes_written, 32'd5);
        chk("t2_pokey_addr", 32'(m_pokey_addr), 32'h0800);

        // Bad magic: rejected with checking, loads without it
        sel = 1'b0;
        set_rom(8'h31, 4);
        model_expect(1'b0, 32'd4, 16'h0000, 1'b0, 1'b1);
        stream_load(1'b1);
        chk("t3_err_code", 32'(m_err_code), 32'd1);
        sel = 1'b1;
        set_rom(8'h41, 4);
        model_expect(1'b1, 32'd4, 16'h0000, 1'b0, 1'b1);
        stream_load(1'b1);
        chk("t4_bytes_written", m_bytes_written, 32'd4);

        // Size limits
        sel = 1'b0;
        rom.delete();
        model_expect(1'b0, MAXB + 32'd1, 16'h0041, 1'b1, 1'b0);
        stream_load(1'b0);
        chk("t5_err_code", 32'(m_err_code), 32'd2);
        chk("t5_pokey_addr", 32'(m_pokey_addr), 32'h0450);
        model_expect(1'b0, 32'd0, 16'h0001, 1'b0, 1'b0);
        stream_load(1'b0);
        chk("t6_err_code", 32'(m_err_code), 32'd2);
        chk("t6_pokey_addr", 32'(m_pokey_addr), 32'h4000);

        // Slow ack: held request checked every cycle by the compare process
        ack_delay = 5;
        set_rom(8'h51, 4);
        model_expect(1'b0, 32'd4, 16'h0400, 1'b0, 1'b0);
        stream_load(1'b1);
        chk("t7_pokey_addr", 32'(m_pokey_addr), 32'h0440);
        ack_delay = 0;

        // Abort while a write is pending
        ack_en = 1'b0;
        set_rom(8'h21, 6);
        model_expect(1'b0, 32'd6, 16'h0000, 1'b0, 1'b0);
        do_start();
        for (int i = 0; i < 128; i++) send_byte(hdr[i]);
        send_byte(rom[0]);
        send_byte(rom[1]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_wr_req) break;
        end
        chk("t8_wr_req_pending", 32'(m_wr_req), 32'd1);
        @(posedge clk); #1;
        exp_code = 3;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t8_wr_req_dropped", 32'(m_wr_req), 32'd0);
        wait_end();
        chk("t8_err_code", 32'(m_err_code), 32'd3);
        exp_q.delete();
        ack_en = 1'b1;

        // Asynchronous reset in the middle of DATA
        set_rom(8'h61, 6);
        model_expect(1'b0, 32'd6, 16'h8000, 1'b1, 1'b0);
        do_start();
        for (int i = 0; i < 128; i++) send_byte(hdr[i]);
        for (int i = 0; i < 3; i++) send_byte(rom[i]);
        @(negedge clk);
        chk("t9_pre_bytes_written", m_bytes_written, 32'd2);
        chk("t9_pre_wr_be", 32'(m_wr_be), 32'h1);
        @(posedge clk); #2;
        comp_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_all_zero("t9_reset");
        @(negedge clk); reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
